// File: rtl/femto_lsu_pkg.sv
// Shared types and constants for the femto load/store unit.
// The funct3 constants are also used by the core decoder.
package femto_lsu_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE   = 2'd0,
    LSU_ACCESS = 2'd1,
    LSU_RESP   = 2'd2
  } lsu_state_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  typedef struct packed {
    logic        store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/femto_lsu_lane_align.sv
// Byte-lane steering: request legality, store mask/replication and
// load shift with sign/zero extension. Purely combinational.
module lsu_lane_align
  import femto_lsu_pkg::*;
(
  input  logic        store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        illegal,
  output logic        misaligned,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);
  logic [1:0]                          size;
  logic [NUM_LANES-1:0][VEC_W-1:0]     lanes;
  logic [31:0]                         shifted;
  logic                                sext;

  assign size    = funct3[1:0];
  assign illegal = (size == 2'b11) || (store && funct3[2]);

  always_comb begin
    misaligned = 1'b0;
    wmask      = 4'b0000;
    case (size)
      SZ_B: wmask = 4'b0001 << off;
      SZ_H: begin
        misaligned = off[0];
        wmask      = 4'b0011 << {off[1], 1'b0};
      end
      SZ_W: begin
        misaligned = |off;
        wmask      = 4'b1111;
      end
      default: ;
    endcase
    if (!store) wmask = 4'b0000;
  end

  // Each lane picks the store byte it would carry for the given size, so the
  // memory sees the right byte regardless of which lanes are enabled.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lanes[i] = (size == SZ_B) ? wdata[VEC_W-1:0] :
                      (size == SZ_H) ? wdata[(i%2)*VEC_W +: VEC_W] :
                                       wdata[i*VEC_W +: VEC_W];
  end
  assign wdata_rep = lanes;

  assign shifted = rdata >> {off, 3'b000};
  assign sext    = ~funct3[2];

  always_comb begin
    case (size)
      SZ_B:    rdata_ext = {{24{sext & shifted[7]}},  shifted[7:0]};
      SZ_H:    rdata_ext = {{16{sext & shifted[15]}}, shifted[15:0]};
      default: rdata_ext = shifted;
    endcase
  end

endmodule

// File: rtl/femto_lsu.sv
// Single-outstanding load/store unit: accept, one handshaked memory word
// access with timeout, then a one-cycle response pulse.
module femto_lsu
  import femto_lsu_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  lsu_state_e  state;
  lsu_req_t    req_q;
  lsu_req_t    cur;
  logic [7:0]  wait_cnt;

  logic        illegal, misaligned;
  logic [3:0]  wmask;
  logic [31:0] wdata_rep, rdata_ext;

  // In IDLE the aligner looks at the live request; afterwards at the latched one.
  always_comb begin
    cur = req_q;
    if (state == LSU_IDLE) cur = '{req_store, req_funct3, req_addr, req_wdata};
  end

  lsu_lane_align u_align (
    .store      (cur.store),
    .funct3     (cur.funct3),
    .off        (cur.addr[1:0]),
    .wdata      (cur.wdata),
    .rdata      (mem_rdata),
    .illegal    (illegal),
    .misaligned (misaligned),
    .wmask      (wmask),
    .wdata_rep  (wdata_rep),
    .rdata_ext  (rdata_ext)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LSU_IDLE;
      req_q     <= '0;
      wait_cnt  <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wmask <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        LSU_IDLE: begin
          if (req_valid) begin
            req_q     <= cur;
            req_ready <= 1'b0;
            if (illegal || misaligned) begin
              state     <= LSU_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state     <= LSU_ACCESS;
              wait_cnt  <= '0;
              mem_valid <= 1'b1;
              mem_addr  <= word_addr(cur.addr);
              mem_wmask <= wmask;
              mem_wdata <= wdata_rep;
            end
          end
        end
        LSU_ACCESS: begin
          if (mem_ready) begin
            state     <= LSU_RESP;
            mem_valid <= 1'b0;
            mem_wmask <= '0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= req_q.store ? '0 : rdata_ext;
          end else if (wait_cnt == WAIT_LAST) begin
            state     <= LSU_RESP;
            mem_valid <= 1'b0;
            mem_wmask <= '0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else if (wait_cnt != 8'hFF) begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        LSU_RESP: begin
          state     <= LSU_IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= LSU_IDLE;
          req_ready <= 1'b1;
          mem_valid <= 1'b0;
          mem_wmask <= '0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
